// File: rtl/ccr_unit_if.sv
// ccr_unit_if: bus bundle for the condition code register unit.
//   Alu flags (alu_c/z/v/n), update mode, direct CCR write (ccr_we/ccr_in),
//   registered ccr, condition selector cc / cc_true, and the DBcc request
//   (dbcc_start/dbcc_count) and result (busy/done/branch/count_out) lines.
//   master: the block driving flags and requests; slave: ccr_unit.
interface ccr_unit_if #(parameter int bits = 16);
    logic            alu_c, alu_z, alu_v, alu_n;
    logic [1:0]      upd_mode;
    logic            ccr_we;
    logic [4:0]      ccr_in;
    logic [4:0]      ccr;
    logic [3:0]      cc;
    logic            cc_true;
    logic            dbcc_start;
    logic [bits-1:0] dbcc_count;
    logic            dbcc_busy;
    logic            dbcc_done;
    logic            dbcc_branch;
    logic [bits-1:0] dbcc_count_out;

    modport master (
        output alu_c, alu_z, alu_v, alu_n, upd_mode, ccr_we, ccr_in, cc,
               dbcc_start, dbcc_count,
        input  ccr, cc_true, dbcc_busy, dbcc_done, dbcc_branch, dbcc_count_out
    );
    modport slave (
        input  alu_c, alu_z, alu_v, alu_n, upd_mode, ccr_we, ccr_in, cc,
               dbcc_start, dbcc_count,
        output ccr, cc_true, dbcc_busy, dbcc_done, dbcc_branch, dbcc_count_out
    );
endinterface

// File: rtl/ccr_unit.sv
// ccr_unit: 68000-style condition code register with DBcc loop sequencer.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : ccr_unit_if.slave
//     - ccr {X,N,Z,V,C} updated from Alu flags per upd_mode, or loaded
//       directly by ccr_we (which wins over upd_mode)
//     - cc_true: combinational decode of cc against the registered ccr
//     - DBcc: start latches cc/count; EVAL tests the condition, DEC
//       decrements when false, DONE pulses dbcc_done for one cycle
module ccr_unit #(
    parameter int bits = 16
) (
    input  logic      clk,
    input  logic      reset,
    ccr_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, DEC, DONE} state_t;

    typedef struct packed {
        logic [3:0]      cc;
        logic [bits-1:0] count;
    } dbcc_req_t;

    localparam int XB = 4, NB = 3, ZB = 2, VB = 1, CB = 0;

    function automatic logic cc_eval(input logic [3:0] sel, input logic [4:0] f);
        logic n, z, v, c;
        n = f[NB]; z = f[ZB]; v = f[VB]; c = f[CB];
        case (sel)
            4'h0: cc_eval = 1'b1;
            4'h1: cc_eval = 1'b0;
            4'h2: cc_eval = ~c & ~z;
            4'h3: cc_eval = c | z;
            4'h4: cc_eval = ~c;
            4'h5: cc_eval = c;
            4'h6: cc_eval = ~z;
            4'h7: cc_eval = z;
            4'h8: cc_eval = ~v;
            4'h9: cc_eval = v;
            4'hA: cc_eval = ~n;
            4'hB: cc_eval = n;
            4'hC: cc_eval = n ~^ v;
            4'hD: cc_eval = n ^ v;
            4'hE: cc_eval = ~z & (n ~^ v);
            default: cc_eval = z | (n ^ v);
        endcase
    endfunction

    // ---------------- condition code register ----------------
    logic [4:0] ccr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ccr_q <= '0;
        end else if (bus.ccr_we) begin
            ccr_q <= bus.ccr_in;
        end else begin
            case (bus.upd_mode)
                2'b01: ccr_q <= {bus.alu_c, bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
                // extended ops chain multi-word results: Z can only clear
                2'b10: ccr_q <= {bus.alu_c, bus.alu_n, ccr_q[ZB] & bus.alu_z,
                                 bus.alu_v, bus.alu_c};
                2'b11: ccr_q <= {ccr_q[XB], bus.alu_n, bus.alu_z, 1'b0, 1'b0};
                default: ccr_q <= ccr_q;
            endcase
        end
    end

    assign bus.ccr     = ccr_q;
    assign bus.cc_true = cc_eval(bus.cc, ccr_q);

    // ---------------- DBcc sequencer ----------------
    state_t          state, next;
    dbcc_req_t       req_q;
    logic            branch_q;
    logic [bits-1:0] count_q;
    logic            cond_now;
    logic [bits-1:0] dec_val;

    // EVAL reads ccr_q, i.e. the value registered before the EVAL edge
    assign cond_now = cc_eval(req_q.cc, ccr_q);
    assign dec_val  = req_q.count - {{(bits-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (bus.dbcc_start) next = EVAL;
            EVAL:    next = cond_now ? DONE : DEC;
            DEC:     next = DONE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        bus.dbcc_busy = (state != IDLE);
        bus.dbcc_done = (state == DONE);
    end

    // results are written on the edge entering DONE and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= '0;
            branch_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (state == IDLE && bus.dbcc_start) begin
                req_q.cc    <= bus.cc;
                req_q.count <= bus.dbcc_count;
            end
            if (state == EVAL && cond_now) begin
                branch_q <= 1'b0;
                count_q  <= req_q.count;
            end
            if (state == DEC) begin
                count_q  <= dec_val;
                branch_q <= ~&dec_val;  // loop exits when the counter wraps to -1
            end
        end
    end

    assign bus.dbcc_branch    = branch_q;
    assign bus.dbcc_count_out = count_q;
endmodule

// File: doc/ccr_unit.md
CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 Parameter bits, default 16, is the width of the loop counter datapath and matches the Alu width.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  is the synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 Ports alu_c, alu_z, alu_v, alu_n  input  1 each  are the carry, zero, overflow and negative flags from the Alu.
REQ-005 Port upd_mode  input  2  selects the flag update: 00 hold, 01 arith, 10 extended, 11 logic.
REQ-006 Port ccr_we  input  1  is a direct CCR write strobe.
REQ-007 Port ccr_in  input  5  is the direct write data, ordered {X,N,Z,V,C}.
REQ-008 Port ccr  output  5  is the registered condition code register, ordered {X,N,Z,V,C}.
REQ-009 Port cc  input  4  is the 68000 condition code selector.
REQ-010 Port cc_true  output  1  is the combinational result of cc evaluated on the registered ccr.
REQ-011 Port dbcc_start  input  1  is a one-cycle request to start a DBcc evaluation.
REQ-012 Port dbcc_count  input  bits  is the loop counter value, sampled with dbcc_start.
REQ-013 Port dbcc_busy  output  1  is high while a DBcc operation is in progress.
REQ-014 Port dbcc_done  output  1  is a one-cycle pulse marking valid DBcc results.
REQ-015 Port dbcc_branch  output  1  is high when the DBcc branch is taken; valid while dbcc_done is high.
REQ-016 Port dbcc_count_out  output  bits  is the updated counter; valid while dbcc_done is high.

Function
REQ-017 Update mode arith (01) SHALL load X=alu_c, N=alu_n, Z=alu_z, V=alu_v and C=alu_c.
REQ-018 Update mode extended (10) SHALL update like arith, except Z: new Z = old Z AND alu_z (Z only clears, never sets).
REQ-019 Update mode logic (11) SHALL load N=alu_n and Z=alu_z, clear V and C, and keep X.
REQ-020 Update mode hold (00) SHALL leave ccr unchanged.
REQ-021 When ccr_we and a non-hold upd_mode occur in the same cycle, ccr_we SHALL win and ccr SHALL load ccr_in.
REQ-022 cc_true SHALL decode cc as follows: 0 T=1; 1 F=0; 2 HI=~C&~Z; 3 LS=C|Z; 4 CC=~C; 5 CS=C; 6 NE=~Z; 7 EQ=Z; 8 VC=~V; 9 VS=V; A PL=~N; B MI=N; C GE=N~^V; D LT=N^V; E GT=~Z&(N~^V); F LE=Z|(N^V).
REQ-023 The DBcc FSM SHALL have the states IDLE, EVAL, DEC and DONE.
REQ-024 From IDLE, dbcc_start SHALL latch cc and dbcc_count and move the FSM to EVAL.
REQ-025 In EVAL, the FSM SHALL evaluate the latched cc on the current ccr.
REQ-026 If that condition is true, EVAL SHALL go to DONE with branch=0 and the count unchanged.
REQ-027 If that condition is false, EVAL SHALL go to DEC.
REQ-028 DEC SHALL compute count-1 modulo 2^bits; branch=0 if the result is all ones, else branch=1; then go to DONE.
REQ-029 DONE SHALL assert dbcc_done for exactly one cycle and then return to IDLE.
REQ-030 dbcc_busy SHALL be high in EVAL, DEC and DONE.
REQ-031 Latency from dbcc_start SHALL be 2 cycles to dbcc_done when the condition is true, and 3 cycles when it is false.
REQ-032 dbcc_start while busy SHALL be ignored, with no change to the latched values.
REQ-033 dbcc_branch and dbcc_count_out SHALL hold their last values until the next DONE.
REQ-034 A ccr update in the EVAL cycle SHALL NOT affect that evaluation; EVAL uses ccr as registered before that edge.

Reset
REQ-035 reset SHALL set ccr=00000, the FSM to IDLE, dbcc_busy=0, dbcc_done=0, dbcc_branch=0 and dbcc_count_out=0.
REQ-036 reset SHALL take priority over ccr_we, upd_mode and dbcc_start.
REQ-037 reset in any FSM state SHALL abort the operation, with no dbcc_done pulse.

Verification
REQ-038 Reset check: pulse reset -> ccr=00000, dbcc_busy=0, dbcc_done=0.
REQ-039 Arith update: flags of 7FFF+0001 (c=0,z=0,v=1,n=1), upd_mode=01 -> ccr=01010; cc=C gives cc_true=1; cc=D gives 0.
REQ-040 Extended Z: ccr=00100, alu_z=1, mode 10 -> Z stays 1; then alu_z=0 -> Z=0; then alu_z=1 -> Z stays 0.
REQ-041 Write priority: ccr_we=1 with ccr_in=10001 and upd_mode=01 with flags all 1, same cycle -> ccr=10001.
REQ-042 DBcc false: cc=1, count=0005 -> done at +3, branch=1, count_out=0004; count=0000 -> count_out=FFFF, branch=0.
REQ-043 DBcc true and abort: cc=0, count=0005 -> done at +2, branch=0, count_out=0005; then start again, reset in DEC -> no done, IDLE.
